// File: rtl/requant_act_pipe.sv
// Two-stage requantise + activation pipeline: shift/offset per lane, then clamp with
// ReLU or signed saturation, and a saturating counter of clipped lanes.
module requant_act_pipe #(
  parameter int unsigned CH         = 4,
  parameter int unsigned IN_W       = 14,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned PRE_SHIFT  = 2,
  parameter int unsigned OFFSET     = 128,
  parameter int unsigned POST_SHIFT = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    din,
  input  logic [1:0]            act_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   dout,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      clip_cnt
);

  localparam int unsigned W2 = IN_W + 2;
  localparam int unsigned NW = $clog2(CH + 1);
  localparam logic signed [W2-1:0] SAT_HI = W2'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W2-1:0] SAT_LO = -SAT_HI - W2'(1);
  localparam logic signed [W2-1:0] OFF_S  = W2'(OFFSET);

  logic                  s1_valid;
  logic [CH*W2-1:0]      s1_t2;
  logic [1:0]            s1_mode;
  logic                  s2_valid;
  logic [CH*OUT_W-1:0]   s2_data;
  logic [NW-1:0]         s2_nclip;

  logic                  s1_adv, s2_adv;
  logic [CH*W2-1:0]      t2_d;
  logic [CH*OUT_W-1:0]   clamp_d;
  logic [NW-1:0]         nclip_d;
  logic [CNT_W:0]        cnt_sum;

  logic signed [W2-1:0]  ext [CH];
  logic signed [W2-1:0]  sh  [CH];
  logic signed [W2-1:0]  t1  [CH];
  logic signed [W2-1:0]  v   [CH];
  logic signed [W2-1:0]  c   [CH];
  logic signed [W2-1:0]  lo;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign dout      = s2_data;

  // Stage 1: widened by two bits so the offset subtraction can never overflow.
  always_comb begin
    t2_d = '0;
    for (int k = 0; k < CH; k++) begin
      ext[k] = W2'($signed(din[k*IN_W +: IN_W]));
      sh[k]  = ext[k] >>> PRE_SHIFT;
      t1[k]  = sh[k] - OFF_S;
      t2_d[k*W2 +: W2] = t1[k] >>> POST_SHIFT;
    end
  end

  // Stage 2: modes 10/11 fall back to ReLU.
  always_comb begin
    clamp_d = '0;
    nclip_d = '0;
    lo      = (s1_mode == 2'b01) ? SAT_LO : '0;
    for (int k = 0; k < CH; k++) begin
      v[k] = $signed(s1_t2[k*W2 +: W2]);
      if (v[k] > SAT_HI)   c[k] = SAT_HI;
      else if (v[k] < lo)  c[k] = lo;
      else                 c[k] = v[k];
      clamp_d[k*OUT_W +: OUT_W] = OUT_W'(c[k]);
      nclip_d = nclip_d + NW'(c[k] != v[k]);
    end
  end

  assign cnt_sum = {1'b0, clip_cnt} + (CNT_W + 1)'(s2_nclip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t2    <= '0;
      s1_mode  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_nclip <= '0;
      clip_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_t2   <= t2_d;
          s1_mode <= act_mode;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= clamp_d;
          s2_nclip <= nclip_d;
        end
      end
      if (clr_cnt) begin
        clip_cnt <= '0;
      end else if (s2_valid && out_ready) begin
        clip_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_requant_act_pipe.sv
// Directed bench for requant_act_pipe: vector table, backpressure stream, counter
// saturation/clear and mid-flight reset.
module tb_requant_act_pipe;

  localparam int CH = 4;
  localparam int IN_W = 14;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH*IN_W-1:0]   din;
  logic [1:0]           act_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH*OUT_W-1:0]  dout;
  logic                 clr_cnt;
  logic [CNT_W-1:0]     clip_cnt;

  int errors = 0;
  int checks = 0;
  int cnt_model = 0;

  typedef struct {
    logic [1:0]          mode;
    logic [CH*IN_W-1:0]  din;
    logic [CH*OUT_W-1:0] dout;
    int                  nclip;
  } vec_t;

  vec_t vecs [8];

  requant_act_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .clr_cnt   (clr_cnt),
    .clip_cnt  (clip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*IN_W-1:0] pk_in(input int a, input int b, input int c, input int d);
    logic [IN_W-1:0] x0, x1, x2, x3;
    x0 = a[IN_W-1:0]; x1 = b[IN_W-1:0]; x2 = c[IN_W-1:0]; x3 = d[IN_W-1:0];
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [CH*OUT_W-1:0] pk_out(input int a, input int b, input int c, input int d);
    logic [OUT_W-1:0] x0, x1, x2, x3;
    x0 = a[OUT_W-1:0]; x1 = b[OUT_W-1:0]; x2 = c[OUT_W-1:0]; x3 = d[OUT_W-1:0];
    return {x3, x2, x1, x0};
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single beat through an empty pipe with out_ready high.
  task automatic run_vector(input int idx);
    @(negedge clk);
    in_valid = 1'b1; din = vecs[idx].din; act_mode = vecs[idx].mode; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d_lat1_valid", idx), 64'(out_valid), 64'(0));
    @(negedge clk);
    chk($sformatf("v%0d_valid", idx), 64'(out_valid), 64'(1));
    chk($sformatf("v%0d_dout", idx), 64'(dout), 64'(vecs[idx].dout));
    chk($sformatf("v%0d_cnt_before", idx), 64'(clip_cnt), 64'(cnt_model));
    @(negedge clk);
    cnt_model = sat_add(cnt_model, vecs[idx].nclip);
    chk($sformatf("v%0d_cnt_after", idx), 64'(clip_cnt), 64'(cnt_model));
    chk($sformatf("v%0d_drained", idx), 64'(out_valid), 64'(0));
  endtask

  initial begin
    int sent, recv, occ, cyc;
    logic prev_stall;
    logic [CH*OUT_W-1:0] prev_dout;

    vecs[0] = '{2'b00, pk_in(4096, 512, 1024, 8191), pk_out(28, 0, 4, 59), 0};
    vecs[1] = '{2'b00, pk_in(-4000, -4000, -4000, -4000), pk_out(0, 0, 0, 0), 4};
    vecs[2] = '{2'b01, pk_in(-4000, -4000, -4000, -4000), pk_out(-36, -36, -36, -36), 0};
    vecs[3] = '{2'b01, pk_in(8191, -8192, 512, 4096), pk_out(59, -68, 0, 28), 0};
    vecs[4] = '{2'b00, pk_in(8191, -8192, 512, 4096), pk_out(59, 0, 0, 28), 1};
    vecs[5] = '{2'b10, pk_in(-1, 100, 600, -600), pk_out(0, 0, 0, 0), 3};
    vecs[6] = '{2'b11, pk_in(2000, 3000, -100, 7000), pk_out(11, 19, 0, 50), 1};
    vecs[7] = '{2'b01, pk_in(-4096, 131, 4223, -33), pk_out(-36, -3, 28, -5), 0};

    rst_n = 1'b0; in_valid = 1'b0; din = '0; act_mode = 2'b00; out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_clip_cnt", 64'(clip_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 8; i++) run_vector(i);

    // Backpressure stream: random out_ready, stability under stall, ordering.
    sent = 0; recv = 0; occ = 0; prev_stall = 1'b0; prev_dout = '0;
    for (cyc = 0; cyc < 400 && recv < 10; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(out_valid), 64'(1));
        chk("stall_dout_hold", 64'(dout), 64'(prev_dout));
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      din       = vecs[sent % 8].din;
      act_mode  = vecs[sent % 8].mode;
      #1;
      if (occ == 2 && !out_ready) chk("full_in_ready_low", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        chk($sformatf("stream_dout_%0d", recv), 64'(dout), 64'(vecs[recv % 8].dout));
        cnt_model = sat_add(cnt_model, vecs[recv % 8].nclip);
        recv++;
        occ--;
      end
      if (in_valid && in_ready) begin
        sent++;
        occ++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
    end
    chk("stream_all_received", 64'(recv), 64'(10));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("stream_clip_cnt", 64'(clip_cnt), 64'(cnt_model));

    // Clear, then preload the counter to max-1 by streaming clipping beats.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_idle", 64'(clip_cnt), 64'(0));
    for (int i = 0; i < 16384; i++) begin
      in_valid = 1'b1;
      act_mode = 2'b00;
      din = (i < 16383) ? vecs[1].din : pk_in(-4000, -4000, 4096, 4096);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("preload_max_m1", 64'(clip_cnt), 64'(CNT_MAX - 1));
    cnt_model = CNT_MAX - 1;
    run_vector(1);
    chk("sat_max", 64'(clip_cnt), 64'(CNT_MAX));
    run_vector(1);

    // Clear coinciding with a clipping output transfer.
    @(negedge clk);
    in_valid = 1'b1; din = vecs[1].din; act_mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_race_valid", 64'(out_valid), 64'(1));
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_wins", 64'(clip_cnt), 64'(0));
    cnt_model = 0;

    // Reset with two beats in flight.
    run_vector(1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; din = vecs[2].din; act_mode = 2'b01;
    @(negedge clk);
    din = vecs[3].din;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_full_ready", 64'(in_ready), 64'(0));
    chk("inflight_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_clip_cnt", 64'(clip_cnt), 64'(0));
    chk("midrst_dout", 64'(dout), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_%0d", i), 64'(out_valid), 64'(0));
    end
    chk("post_rst_cnt", 64'(clip_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
